// File: rtl/div.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Shares the start/fin handshake with the shift-add multiplier.
module div #(
    parameter int WN = 16,
    parameter int WD = 8
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          start,
    input  logic [WN-1:0] N,
    input  logic [WD-1:0] D,
    output logic [WN-1:0] Q,
    output logic [WD-1:0] R,
    output logic          busy,
    output logic          dz,
    output logic          fin
);
    localparam int CW = (WN > 1) ? $clog2(WN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [WN-1:0] r_nsh;
    logic [WN-1:0] r_qsh;
    logic [WD-1:0] r_dreg;
    logic [WD:0]   r_p;
    logic [CW-1:0] r_cnt;

    logic [WD:0]   w_pp;
    logic [WD:0]   w_pn;
    logic          w_ge;
    logic [WN-1:0] w_qn;
    logic          w_last;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_pp   = {r_p[WD-1:0], r_nsh[WN-1]};
        w_ge   = (w_pp >= {1'b0, r_dreg});
        w_pn   = w_ge ? (w_pp - {1'b0, r_dreg}) : w_pp;
        w_qn   = {r_qsh[WN-2:0], w_ge};
        w_last = (r_cnt == CW'(WN - 1));
    end

    always_comb begin
        w_state_nx = r_state;
        if (start) begin
            w_state_nx = RUN;
        end else begin
            case (r_state)
                RUN:     if (w_last) w_state_nx = DONE;
                DONE:    w_state_nx = IDLE;
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_nsh  <= '0;
            r_qsh  <= '0;
            r_dreg <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            Q      <= '0;
            R      <= '0;
            busy   <= 1'b0;
            dz     <= 1'b0;
            fin    <= 1'b0;
        end else if (start) begin
            // A load always wins, including over the edge that would raise fin.
            r_nsh  <= N;
            r_qsh  <= '0;
            r_dreg <= D;
            r_p    <= '0;
            r_cnt  <= '0;
            busy   <= 1'b1;
            dz     <= (D == '0);
            fin    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_nsh <= {r_nsh[WN-2:0], 1'b0};
                    r_qsh <= w_qn;
                    r_p   <= w_pn;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        Q    <= dz ? {WN{1'b1}} : w_qn;
                        R    <= dz ? '0 : w_pn[WD-1:0];
                        fin  <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                DONE: begin
                    fin <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// Bench for div: directed handshake cases plus a randomized sweep checked
// against plain integer division.
module tb_div;
    localparam int WN = 16;
    localparam int WD = 8;

    logic          ck = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [WN-1:0] N = '0;
    logic [WD-1:0] D = '0;
    logic [WN-1:0] Q;
    logic [WD-1:0] R;
    logic          busy;
    logic          dz;
    logic          fin;

    int total = 0;
    int fails = 0;

    div #(.WN(WN), .WD(WD)) dut (
        .ck(ck), .rst_n(rst_n), .start(start), .N(N), .D(D),
        .Q(Q), .R(R), .busy(busy), .dz(dz), .fin(fin)
    );

    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load edge, then the state right after it.
    task automatic begin_op(input logic [WN-1:0] n, input logic [WD-1:0] d, input string tag);
        N = n;
        D = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_dz0"}, 32'(dz), 32'(d == '0));
        chk({tag, "_fin0"}, 32'(fin), 32'd0);
    endtask

    // Remaining WN iterations, the fin cycle and the cycle after.
    task automatic finish_op(input logic [WN-1:0] n, input logic [WD-1:0] d, input string tag);
        logic [WN-1:0] q0;
        logic [WD-1:0] r0;
        logic [WN-1:0] eq;
        logic [WD-1:0] er;
        int bad_ctl;
        int unstable;
        q0 = Q;
        r0 = R;
        bad_ctl = 0;
        unstable = 0;
        eq = (d == '0) ? {WN{1'b1}} : WN'(n / d);
        er = (d == '0) ? '0 : WD'(n % d);
        for (int k = 1; k < WN; k++) begin
            tick();
            if (fin !== 1'b0 || busy !== 1'b1) bad_ctl++;
            if (Q !== q0 || R !== r0) unstable++;
        end
        chk({tag, "_run_ctl"}, 32'(bad_ctl), 32'd0);
        chk({tag, "_run_stable"}, 32'(unstable), 32'd0);
        tick();
        chk({tag, "_fin"}, 32'(fin), 32'd1);
        chk({tag, "_Q"}, 32'(Q), 32'(eq));
        chk({tag, "_R"}, 32'(R), 32'(er));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_dz"}, 32'(dz), 32'(d == '0));
        if (d != '0) begin
            chk({tag, "_inv"}, 32'(Q) * 32'(D) + 32'(R), 32'(n));
            chk({tag, "_rltd"}, 32'(R < d), 32'd1);
        end
        tick();
        chk({tag, "_fin_off"}, 32'(fin), 32'd0);
        chk({tag, "_hold"}, {Q, R, 8'h00}, {eq, er, 8'h00});
    endtask

    task automatic run_op(input logic [WN-1:0] n, input logic [WD-1:0] d, input string tag);
        begin_op(n, d, tag);
        finish_op(n, d, tag);
    endtask

    function automatic logic [WN-1:0] pick_n();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return WN'(1);
            2: return {WN{1'b1}};
            3: return {1'b1, {(WN-1){1'b0}}};
            4: return {1'b0, {(WN-1){1'b1}}};
            default: return WN'($urandom);
        endcase
    endfunction

    function automatic logic [WD-1:0] pick_d();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return WD'(1);
            2: return {WD{1'b1}};
            3: return {1'b1, {(WD-1){1'b0}}};
            4: return {1'b0, {(WD-1){1'b1}}};
            default: return WD'($urandom);
        endcase
    endfunction

    initial begin
        int cnt;
        logic [WN-1:0] q0;
        logic [WD-1:0] r0;

        #3;
        chk("rst_out", {Q, R, busy, dz, fin}, '0);
        #20;
        rst_n = 1'b1;
        tick();
        chk("idle_fin", 32'(fin), 32'd0);

        run_op(16'd65025, 8'd255, "roundtrip");
        run_op(16'd1000, 8'd7, "n1000d7");
        run_op(16'd3, 8'd200, "n3d200");
        run_op(16'd65535, 8'd1, "n65535d1");
        run_op(16'd1234, 8'd0, "dz");

        // Abort at iteration 8: no fin for the first operation.
        begin_op(16'd1000, 8'd7, "abort_a");
        for (int k = 0; k < 8; k++) tick();
        chk("abort_nofin", 32'(fin), 32'd0);
        begin_op(16'd50, 8'd9, "abort_b");
        finish_op(16'd50, 8'd9, "abort_b");

        // Restart on the edge that would have raised fin.
        begin_op(16'd40000, 8'd3, "late_a");
        for (int k = 1; k < WN; k++) tick();
        q0 = Q;
        r0 = R;
        begin_op(16'd777, 8'd10, "late_b");
        chk("late_keepQ", 32'(Q), 32'(q0));
        chk("late_keepR", 32'(R), 32'(r0));
        finish_op(16'd777, 8'd10, "late_b");

        // Start held high: only the last loaded operands count.
        start = 1'b1;
        N = 16'd9999; D = 8'd2; tick();
        N = 16'd12345; D = 8'd0; tick();
        begin_op(16'd54321, 8'd123, "hold");
        finish_op(16'd54321, 8'd123, "hold");

        // Asynchronous reset between edges during a divide-by-zero run.
        begin_op(16'd500, 8'd0, "rstmid");
        for (int k = 0; k < 5; k++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out", {Q, R, busy, dz, fin}, '0);
        #2;
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 2 * WN; k++) begin
            tick();
            if (fin !== 1'b0 || busy !== 1'b0) cnt++;
        end
        chk("rstmid_quiet", 32'(cnt), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            run_op(pick_n(), pick_d(), "rand");
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
